// File: rtl/arc_micro_pkg.sv
// arc_micro_pkg: shared microword layout, COND encodings and sequencer states for the ARC control store.
package arc_micro_pkg;
    localparam int ADDR_W = 11;
    localparam int WORD_W = 41;
    localparam int RD_BIT = 19;
    localparam int WR_BIT = 18;
    localparam int COND_LSB = 11;
    localparam int COND_W = 3;
    localparam int JADDR_LSB = 0;
    localparam logic DECODE_PREFIX = 1'b1;
    localparam logic [5:0] OP00_MASK = 6'b111000;
    typedef enum logic [2:0] {
        COND_NEXT, COND_N, COND_Z, COND_V, COND_C, COND_IR13, COND_JUMP, COND_DECODE
    } cond_e;
    typedef enum logic {ST_RUN, ST_WAIT} state_e;
endpackage

// File: rtl/micro_next_addr.sv
// micro_next_addr: combinational next control-store address from COND/JADDR, PSR flags and IR.
module micro_next_addr
    import arc_micro_pkg::*;
(
    input  logic [WORD_W-1:0] MI_WORD,
    input  logic [ADDR_W-1:0] CSAI,
    input  logic [31:0]       IR,
    input  logic [3:0]        PSR_NZVC,
    output logic [ADDR_W-1:0] NEXT
);
    cond_e             cond;
    logic [ADDR_W-1:0] jaddr;
    logic [5:0]        op3;
    logic [7:0]        take;
    logic              unused_bits;
    assign cond  = cond_e'(MI_WORD[COND_LSB +: COND_W]);
    assign jaddr = MI_WORD[JADDR_LSB +: ADDR_W];
    // branch/sethi (op=00) dispatch on op2 alone, so the low op3 bits are dropped
    assign op3   = IR[31:30] == 2'b00 ? IR[24:19] & OP00_MASK : IR[24:19];
    assign take  = {1'b0, 1'b1, IR[13], PSR_NZVC[0], PSR_NZVC[1], PSR_NZVC[2], PSR_NZVC[3], 1'b0};
    assign NEXT  = cond == COND_DECODE ? {DECODE_PREFIX, IR[31:30], op3, 2'b00}
                 : take[cond] ? jaddr : CSAI + 1'b1;
    assign unused_bits = ^{MI_WORD[WORD_W-1:COND_LSB+COND_W], IR[29:25], IR[18:14], IR[12:0]};
endmodule

// File: rtl/micro_sequencer.sv
// micro_sequencer: control-store address register with memory-wait stall and timeout trap.
module micro_sequencer
    import arc_micro_pkg::*;
#(
    parameter int                WAIT_MAX  = 15,
    parameter logic [ADDR_W-1:0] TRAP_ADDR = '0
) (
    input  logic              CLOCK_50,
    input  logic              RESET_InHigh,
    input  logic [WORD_W-1:0] MI_WORD,
    input  logic [31:0]       IR,
    input  logic [3:0]        PSR_NZVC,
    input  logic              MEM_READY,
    output logic [ADDR_W-1:0] CSAI,
    output logic              STALL,
    output logic              MEM_ERR
);
    localparam int CNT_W = $clog2(WAIT_MAX + 1);
    state_e            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [ADDR_W-1:0] next_addr, csai_n;
    logic              memop, err_n;
    micro_next_addr u_next (
        .MI_WORD  (MI_WORD),
        .CSAI     (CSAI),
        .IR       (IR),
        .PSR_NZVC (PSR_NZVC),
        .NEXT     (next_addr)
    );
    assign memop = MI_WORD[RD_BIT] | MI_WORD[WR_BIT];
    always_comb begin
        state_n = state;
        csai_n  = CSAI;
        cnt_n   = cnt;
        err_n   = 1'b0;
        STALL   = 1'b0;
        if (state == ST_RUN) begin
            if (memop && !MEM_READY) begin
                state_n = ST_WAIT;
                cnt_n   = CNT_W'(1);
                STALL   = 1'b1;
            end else begin
                csai_n = next_addr;
            end
        end else if (MEM_READY) begin
            state_n = ST_RUN;
            csai_n  = next_addr;
            cnt_n   = '0;
        end else if (cnt == CNT_W'(WAIT_MAX)) begin
            state_n = ST_RUN;
            csai_n  = TRAP_ADDR;
            cnt_n   = '0;
            err_n   = 1'b1;
            STALL   = 1'b1;
        end else begin
            cnt_n = cnt + 1'b1;
            STALL = 1'b1;
        end
    end
    always_ff @(posedge CLOCK_50) begin
        if (RESET_InHigh) begin
            state   <= ST_RUN;
            CSAI    <= '0;
            cnt     <= '0;
            MEM_ERR <= 1'b0;
        end else begin
            state   <= state_n;
            CSAI    <= csai_n;
            cnt     <= cnt_n;
            MEM_ERR <= err_n;
        end
    end
endmodule
